fetch_buffer: RTL and testbench

- Decoupling FIFO between the instruction-fetch stage and the decode stage, which feeds the dual-issue ID_REG/issue logic.
- Accepts up to 2 fetched instructions per cycle, each with PC, exception and branch-prediction info.
- Presents an in-order pair (slot0, slot1) to decode.
- Absorbs I-cache/decode rate mismatch. Flushed on redirect.

---
 rtl/fetch_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_buffer.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: dual-issue decoupling FIFO between instruction fetch and decode.
// Optional same-cycle empty-buffer bypass is enabled by defining FB_BYPASS_EN.
module fetch_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PTR_W    = $clog2(DEPTH),
  parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             if_readygo,
  output logic             fb_allowin,
  input  logic [1:0]       if_mask,
  input  logic [31:0]      if_pc0,
  input  logic [31:0]      if_pc1,
  input  logic [31:0]      if_inst0,
  input  logic [31:0]      if_inst1,
  input  logic [6:0]       if_excp_code,
  input  logic             if_excp_valid,
  input  logic [31:0]      if_badv,
  input  logic [1:0]       if_pred_taken,
  input  logic [31:0]      if_pred_npc,
  output logic             fb_readygo,
  input  logic             id_allowin,
  output logic [1:0]       fb_mask,
  output logic [31:0]      fb_pc0,
  output logic [31:0]      fb_pc1,
  output logic [31:0]      fb_inst0,
  output logic [31:0]      fb_inst1,
  output logic [1:0]       fb_excp_flag,
  output logic [6:0]       fb_exception,
  output logic [31:0]      fb_badv,
  output logic             fb_pc_taken,
  output logic [31:0]      fb_pc_next,
  output logic [PTR_W:0]   fb_count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp_valid;
    logic [6:0]  excp_code;
    logic [31:0] badv;
    logic        pred_taken;
    logic [31:0] pred_npc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_p1, tail_p1;

  entry_t           in0, in1, bun0, bun1, c0, c1, wd0, wd1;
  logic [1:0]       n_in, n_push, n_pop;
  logic [CNT_W-1:0] avail;
  logic             mask0, mask1, push, pop, we0, we1;

`ifdef FB_BYPASS_EN
  logic             bypass;
  logic [1:0]       n_wr;
  assign bypass = (count_q == '0) && if_readygo && !flush;
`endif

  assign head_p1    = head_q + PTR_W'(1);
  assign tail_p1    = tail_q + PTR_W'(1);
  assign fb_allowin = (count_q <= CNT_W'(DEPTH - 2));
  assign fb_count   = count_q;

  // Incoming slots; exception and badv attach to the lowest valid slot only.
  always_comb begin
    in0 = '0;
    in1 = '0;
    in0.pc         = if_pc0;
    in0.inst       = if_inst0;
    in0.excp_valid = if_excp_valid & if_mask[0];
    in0.pred_taken = if_pred_taken[0];
    in1.pc         = if_pc1;
    in1.inst       = if_inst1;
    in1.excp_valid = if_excp_valid & ~if_mask[0];
    in1.pred_taken = if_pred_taken[1];
    if (in0.excp_valid) begin
      in0.excp_code = if_excp_code;
      in0.badv      = if_badv;
    end
    if (in1.excp_valid) begin
      in1.excp_code = if_excp_code;
      in1.badv      = if_badv;
    end
    if (in0.pred_taken) in0.pred_npc = if_pred_npc;
    if (in1.pred_taken) in1.pred_npc = if_pred_npc;

    bun0 = in0;
    bun1 = in1;
    case (if_mask)
      2'b11:   n_in = 2'd2;
      2'b01:   n_in = 2'd1;
      2'b10: begin
        bun0 = in1;
        n_in = 2'd1;
      end
      default: n_in = 2'd0;
    endcase
  end

  // Output pair selection and slot-pairing rules.
  always_comb begin
    c0    = mem_q[head_q];
    c1    = mem_q[head_p1];
    avail = count_q;
`ifdef FB_BYPASS_EN
    if (bypass) begin
      c0    = bun0;
      c1    = bun1;
      avail = CNT_W'(n_in);
    end
`endif
    mask0 = (avail != '0);
    mask1 = (avail >= CNT_W'(2)) && !c0.pred_taken && !c0.excp_valid && !c1.excp_valid;

    fb_mask      = {mask1, mask0};
    fb_readygo   = mask0;
    fb_pc0       = mask0 ? c0.pc : '0;
    fb_inst0     = mask0 ? c0.inst : NOP_INST;
    fb_pc1       = mask1 ? c1.pc : '0;
    fb_inst1     = mask1 ? c1.inst : NOP_INST;
    fb_excp_flag = {mask1 & c1.excp_valid, mask0 & c0.excp_valid};

    fb_exception = '0;
    fb_badv      = '0;
    if (fb_excp_flag[0]) begin
      fb_exception = c0.excp_code;
      fb_badv      = c0.badv;
    end else if (fb_excp_flag[1]) begin
      fb_exception = c1.excp_code;
      fb_badv      = c1.badv;
    end

    fb_pc_taken = 1'b0;
    fb_pc_next  = '0;
    if (mask1) begin
      fb_pc_taken = c1.pred_taken;
      fb_pc_next  = c1.pred_npc;
    end else if (mask0) begin
      fb_pc_taken = c0.pred_taken;
      fb_pc_next  = c0.pred_npc;
    end
  end

  // Pointer/count update and storage write ports.
  always_comb begin
    push    = if_readygo & fb_allowin & ~flush;
    pop     = fb_readygo & id_allowin & ~flush;
    n_push  = push ? n_in : 2'd0;
    n_pop   = pop ? ({1'b0, mask0} + {1'b0, mask1}) : 2'd0;
    we0     = push & (n_in != 2'd0);
    we1     = push & (n_in == 2'd2);
    wd0     = bun0;
    wd1     = bun1;
    head_d  = head_q + PTR_W'(n_pop);
    tail_d  = tail_q + PTR_W'(n_push);
    count_d = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
`ifdef FB_BYPASS_EN
    n_wr = 2'd0;
    // Slots consumed straight from fetch never touch storage.
    if (bypass) begin
      n_wr    = n_push - n_pop;
      we0     = (n_wr != 2'd0);
      we1     = (n_wr == 2'd2);
      wd0     = (n_pop == 2'd1) ? bun1 : bun0;
      head_d  = head_q;
      tail_d  = tail_q + PTR_W'(n_wr);
      count_d = CNT_W'(n_wr);
    end
`endif
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem_q[tail_q] <= wd0;
    if (we1) mem_q[tail_p1] <= wd1;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scoreboard bench for fetch_buffer (default build, DEPTH = 8).
module tb_fetch_buffer;

  localparam logic [31:0] NOP = 32'h0340_0000;

  logic        clk, rstn, flush, if_readygo, fb_allowin, if_excp_valid;
  logic        fb_readygo, id_allowin, fb_pc_taken;
  logic [1:0]  if_mask, if_pred_taken, fb_mask, fb_excp_flag;
  logic [31:0] if_pc0, if_pc1, if_inst0, if_inst1, if_badv, if_pred_npc;
  logic [31:0] fb_pc0, fb_pc1, fb_inst0, fb_inst1, fb_badv, fb_pc_next;
  logic [6:0]  if_excp_code, fb_exception;
  logic [3:0]  fb_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] badv;
    logic [31:0] npc;
    logic        excp;
    logic        taken;
    logic [6:0]  code;
  } item_t;

  item_t sb[$];

  fetch_buffer #(.DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .if_readygo(if_readygo), .fb_allowin(fb_allowin),
    .if_mask(if_mask), .if_pc0(if_pc0), .if_pc1(if_pc1), .if_inst0(if_inst0),
    .if_inst1(if_inst1), .if_excp_code(if_excp_code), .if_excp_valid(if_excp_valid),
    .if_badv(if_badv), .if_pred_taken(if_pred_taken), .if_pred_npc(if_pred_npc),
    .fb_readygo(fb_readygo), .id_allowin(id_allowin), .fb_mask(fb_mask), .fb_pc0(fb_pc0),
    .fb_pc1(fb_pc1), .fb_inst0(fb_inst0), .fb_inst1(fb_inst1), .fb_excp_flag(fb_excp_flag),
    .fb_exception(fb_exception), .fb_badv(fb_badv), .fb_pc_taken(fb_pc_taken),
    .fb_pc_next(fb_pc_next), .fb_count(fb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: compares every cycle at negedge, then applies this edge's push/pop.
  int          mon_n;
  logic        mon_m0, mon_m1, mon_tk;
  item_t       mon_s0, mon_s1, mon_it, mon_last;
  logic [31:0] mon_pc0, mon_pc1, mon_i0, mon_i1, mon_badv;
  logic [6:0]  mon_code;
  logic [1:0]  mon_flag;

  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
    end else begin
      mon_n  = sb.size();
      mon_s0 = '{default: '0};
      mon_s1 = '{default: '0};
      if (mon_n >= 1) mon_s0 = sb[0];
      if (mon_n >= 2) mon_s1 = sb[1];
      mon_m0 = (mon_n >= 1);
      mon_m1 = (mon_n >= 2) && !mon_s0.taken && !mon_s0.excp && !mon_s1.excp;
      checks++;
      if (fb_mask !== {mon_m1, mon_m0} || fb_readygo !== mon_m0) begin
        errors++;
        $display("FAIL mon_mask t=%0t got mask=%b rdy=%b want mask=%b rdy=%b", $time, fb_mask,
                 fb_readygo, {mon_m1, mon_m0}, mon_m0);
      end
      checks++;
      if (fb_count !== 4'(mon_n) || fb_allowin !== (mon_n <= 6)) begin
        errors++;
        $display("FAIL mon_count t=%0t got count=%0d allowin=%b want count=%0d allowin=%b",
                 $time, fb_count, fb_allowin, mon_n, (mon_n <= 6));
      end
      mon_pc0 = mon_m0 ? mon_s0.pc : 32'd0;
      mon_i0  = mon_m0 ? mon_s0.inst : NOP;
      mon_pc1 = mon_m1 ? mon_s1.pc : 32'd0;
      mon_i1  = mon_m1 ? mon_s1.inst : NOP;
      checks++;
      if ({fb_pc0, fb_inst0, fb_pc1, fb_inst1} !== {mon_pc0, mon_i0, mon_pc1, mon_i1}) begin
        errors++;
        $display("FAIL mon_slots t=%0t got %h %h %h %h want %h %h %h %h", $time, fb_pc0, fb_inst0,
                 fb_pc1, fb_inst1, mon_pc0, mon_i0, mon_pc1, mon_i1);
      end
      mon_flag = {mon_m1 && mon_s1.excp, mon_m0 && mon_s0.excp};
      mon_code = mon_flag[0] ? mon_s0.code : (mon_flag[1] ? mon_s1.code : 7'd0);
      mon_badv = mon_flag[0] ? mon_s0.badv : (mon_flag[1] ? mon_s1.badv : 32'd0);
      checks++;
      if ({fb_excp_flag, fb_exception, fb_badv} !== {mon_flag, mon_code, mon_badv}) begin
        errors++;
        $display("FAIL mon_excp t=%0t got flag=%b code=%h badv=%h want flag=%b code=%h badv=%h",
                 $time, fb_excp_flag, fb_exception, fb_badv, mon_flag, mon_code, mon_badv);
      end
      mon_last = mon_m1 ? mon_s1 : mon_s0;
      mon_tk   = mon_m0 && mon_last.taken;
      checks++;
      if (fb_pc_taken !== mon_tk || (mon_tk && fb_pc_next !== mon_last.npc)) begin
        errors++;
        $display("FAIL mon_pred t=%0t got taken=%b next=%h want taken=%b next=%h", $time,
                 fb_pc_taken, fb_pc_next, mon_tk, mon_last.npc);
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (id_allowin && mon_m0) begin
          void'(sb.pop_front());
          if (mon_m1) void'(sb.pop_front());
        end
        if (if_readygo && mon_n <= 6) begin
          if (if_mask[0]) begin
            mon_it.pc    = if_pc0;
            mon_it.inst  = if_inst0;
            mon_it.excp  = if_excp_valid;
            mon_it.code  = if_excp_valid ? if_excp_code : 7'd0;
            mon_it.badv  = if_excp_valid ? if_badv : 32'd0;
            mon_it.taken = if_pred_taken[0];
            mon_it.npc   = if_pred_npc;
            sb.push_back(mon_it);
          end
          if (if_mask[1]) begin
            mon_it.pc    = if_pc1;
            mon_it.inst  = if_inst1;
            mon_it.excp  = if_excp_valid && !if_mask[0];
            mon_it.code  = mon_it.excp ? if_excp_code : 7'd0;
            mon_it.badv  = mon_it.excp ? if_badv : 32'd0;
            mon_it.taken = if_pred_taken[1];
            mon_it.npc   = if_pred_npc;
            sb.push_back(mon_it);
          end
        end
      end
    end
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bundle(input logic [1:0] m, input logic [31:0] p0, input logic [31:0] p1,
                        input logic ev, input logic [6:0] ec, input logic [1:0] tk,
                        input logic [31:0] npc);
    if_readygo    = 1'b1;
    if_mask       = m;
    if_pc0        = p0;
    if_pc1        = p1;
    if_inst0      = p0 ^ 32'h5a5a_0013;
    if_inst1      = p1 ^ 32'h5a5a_0013;
    if_excp_valid = ev;
    if_excp_code  = ec;
    if_badv       = ev ? ((m[0] ? p0 : p1) ^ 32'h0000_0f00) : 32'd0;
    if_pred_taken = tk;
    if_pred_npc   = npc;
  endtask

  task automatic idle();
    if_readygo    = 1'b0;
    if_mask       = 2'b00;
    if_excp_valid = 1'b0;
    if_pred_taken = 2'b00;
  endtask

  task automatic drain(output bit ok);
    idle();
    id_allowin = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      go(1);
      if (fb_count == 4'd0) begin
        ok = 1'b1;
        break;
      end
    end
    id_allowin = 1'b0;
  endtask

  task automatic test_reset();
    go(1);
    checks++;
    if ({fb_readygo, fb_mask, fb_allowin, fb_count} !== {1'b0, 2'b00, 1'b1, 4'd0} ||
        {fb_inst0, fb_inst1} !== {NOP, NOP} || {fb_pc0, fb_pc1, fb_badv, fb_pc_next} !== '0 ||
        {fb_excp_flag, fb_exception, fb_pc_taken} !== '0) begin
      errors++;
      $display("FAIL reset got rdy=%b mask=%b allow=%b cnt=%0d inst0=%h inst1=%h pc0=%h want 0 00 1 0 %h %h 0",
               fb_readygo, fb_mask, fb_allowin, fb_count, fb_inst0, fb_inst1, fb_pc0, NOP, NOP);
    end
    rstn = 1'b1;
  endtask

  task automatic test_pass_through();
    id_allowin = 1'b1;
    bundle(2'b11, 32'h1c00_0000, 32'h1c00_0004, 1'b0, 7'd0, 2'b00, 32'd0);
    go(1);
    idle();
    checks++;
    if (fb_mask !== 2'b11 || fb_pc0 !== 32'h1c00_0000 || fb_pc1 !== 32'h1c00_0004) begin
      errors++;
      $display("FAIL pass_pair got mask=%b pc0=%h pc1=%h want 11 1c000000 1c000004", fb_mask,
               fb_pc0, fb_pc1);
    end
    go(1);
    checks++;
    if (fb_count !== 4'd0) begin
      errors++;
      $display("FAIL pass_empty got count=%0d want 0", fb_count);
    end
    bundle(2'b00, 32'h1c00_0008, 32'h1c00_000c, 1'b0, 7'd0, 2'b00, 32'd0);
    go(1);
    idle();
    checks++;
    if (fb_count !== 4'd0 || fb_readygo !== 1'b0) begin
      errors++;
      $display("FAIL pass_mask00 got count=%0d rdy=%b want 0 0", fb_count, fb_readygo);
    end
    id_allowin = 1'b0;
  endtask

  task automatic test_full();
    bit ok;
    id_allowin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bundle(2'b11, 32'h1c00_1000 + 32'(i * 8), 32'h1c00_1004 + 32'(i * 8), 1'b0, 7'd0, 2'b00,
             32'd0);
      go(1);
    end
    checks++;
    if (fb_count !== 4'd8 || fb_allowin !== 1'b0) begin
      errors++;
      $display("FAIL full_8 got count=%0d allowin=%b want 8 0", fb_count, fb_allowin);
    end
    bundle(2'b11, 32'h1c00_2000, 32'h1c00_2004, 1'b0, 7'd0, 2'b00, 32'd0);
    go(2);
    idle();
    checks++;
    if (fb_count !== 4'd8 || fb_pc0 !== 32'h1c00_1000 || fb_pc1 !== 32'h1c00_1004) begin
      errors++;
      $display("FAIL full_hold got count=%0d pc0=%h pc1=%h want 8 1c001000 1c001004", fb_count,
               fb_pc0, fb_pc1);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_drain got count=%0d want 0 within 20 cycles", fb_count);
    end
    for (int i = 0; i < 4; i++) begin
      bundle((i == 3) ? 2'b01 : 2'b11, 32'h1c00_3000 + 32'(i * 8), 32'h1c00_3004 + 32'(i * 8),
             1'b0, 7'd0, 2'b00, 32'd0);
      go(1);
    end
    idle();
    checks++;
    if (fb_count !== 4'd7 || fb_allowin !== 1'b0) begin
      errors++;
      $display("FAIL full_7 got count=%0d allowin=%b want 7 0", fb_count, fb_allowin);
    end
    drain(ok);
  endtask

  task automatic test_pred_taken();
    bit ok;
    id_allowin = 1'b0;
    bundle(2'b11, 32'h1c00_0200, 32'h1c00_0204, 1'b0, 7'd0, 2'b01, 32'h1c00_0100);
    go(1);
    idle();
    checks++;
    if (fb_mask !== 2'b01 || fb_pc_taken !== 1'b1 || fb_pc_next !== 32'h1c00_0100 ||
        fb_count !== 4'd2) begin
      errors++;
      $display("FAIL pred_slot0 got mask=%b taken=%b next=%h count=%0d want 01 1 1c000100 2",
               fb_mask, fb_pc_taken, fb_pc_next, fb_count);
    end
    id_allowin = 1'b1;
    go(1);
    id_allowin = 1'b0;
    checks++;
    if (fb_mask !== 2'b01 || fb_pc0 !== 32'h1c00_0204 || fb_pc_taken !== 1'b0) begin
      errors++;
      $display("FAIL pred_after got mask=%b pc0=%h taken=%b want 01 1c000204 0", fb_mask, fb_pc0,
               fb_pc_taken);
    end
    drain(ok);
    bundle(2'b11, 32'h1c00_0400, 32'h1c00_0404, 1'b0, 7'd0, 2'b10, 32'h1c00_0800);
    go(1);
    idle();
    checks++;
    if (fb_mask !== 2'b11 || fb_pc_taken !== 1'b1 || fb_pc_next !== 32'h1c00_0800) begin
      errors++;
      $display("FAIL pred_slot1 got mask=%b taken=%b next=%h want 11 1 1c000800", fb_mask,
               fb_pc_taken, fb_pc_next);
    end
    drain(ok);
  endtask

  task automatic test_exception();
    bit ok;
    id_allowin = 1'b0;
    bundle(2'b01, 32'h1c00_0300, 32'd0, 1'b1, 7'h08, 2'b00, 32'd0);
    go(1);
    bundle(2'b10, 32'd0, 32'h1c00_0324, 1'b1, 7'h0a, 2'b00, 32'd0);
    go(1);
    bundle(2'b11, 32'h1c00_0310, 32'h1c00_0314, 1'b0, 7'd0, 2'b00, 32'd0);
    go(1);
    idle();
    checks++;
    if (fb_mask !== 2'b01 || fb_excp_flag !== 2'b01 || fb_exception !== 7'h08 ||
        fb_badv !== 32'h1c00_0c00 || fb_count !== 4'd4) begin
      errors++;
      $display("FAIL excp_slot0 got mask=%b flag=%b code=%h badv=%h cnt=%0d want 01 01 08 1c000c00 4",
               fb_mask, fb_excp_flag, fb_exception, fb_badv, fb_count);
    end
    id_allowin = 1'b1;
    go(1);
    id_allowin = 1'b0;
    checks++;
    if (fb_mask !== 2'b01 || fb_pc0 !== 32'h1c00_0324 || fb_exception !== 7'h0a) begin
      errors++;
      $display("FAIL excp_mask10 got mask=%b pc0=%h code=%h want 01 1c000324 0a", fb_mask, fb_pc0,
               fb_exception);
    end
    id_allowin = 1'b1;
    go(1);
    id_allowin = 1'b0;
    checks++;
    if (fb_mask !== 2'b11 || fb_excp_flag !== 2'b00 || fb_exception !== 7'd0 ||
        fb_pc1 !== 32'h1c00_0314) begin
      errors++;
      $display("FAIL excp_clear got mask=%b flag=%b code=%h pc1=%h want 11 00 00 1c000314",
               fb_mask, fb_excp_flag, fb_exception, fb_pc1);
    end
    drain(ok);
  endtask

  task automatic test_wrap();
    bit ok;
    flush = 1'b1;
    go(1);
    flush = 1'b0;
    id_allowin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bundle((i == 3) ? 2'b01 : 2'b11, 32'h1c00_5000 + 32'(i * 8), 32'h1c00_5004 + 32'(i * 8),
             1'b0, 7'd0, 2'b00, 32'd0);
      go(1);
    end
    idle();
    id_allowin = 1'b1;
    go(3);
    checks++;
    if (fb_count !== 4'd1 || fb_pc0 !== 32'h1c00_5018) begin
      errors++;
      $display("FAIL wrap_head6 got count=%0d pc0=%h want 1 1c005018", fb_count, fb_pc0);
    end
    bundle(2'b11, 32'h1c00_6000, 32'h1c00_6004, 1'b0, 7'd0, 2'b00, 32'd0);
    go(1);
    idle();
    id_allowin = 1'b0;
    checks++;
    if (fb_count !== 4'd2 || fb_mask !== 2'b11 || fb_pc0 !== 32'h1c00_6000 ||
        fb_pc1 !== 32'h1c00_6004) begin
      errors++;
      $display("FAIL wrap_pair got count=%0d mask=%b pc0=%h pc1=%h want 2 11 1c006000 1c006004",
               fb_count, fb_mask, fb_pc0, fb_pc1);
    end
    id_allowin = 1'b1;
    go(1);
    id_allowin = 1'b0;
    bundle(2'b01, 32'h1c00_7000, 32'd0, 1'b0, 7'd0, 2'b00, 32'd0);
    go(1);
    idle();
    checks++;
    if (fb_count !== 4'd1 || fb_pc0 !== 32'h1c00_7000) begin
      errors++;
      $display("FAIL wrap_after got count=%0d pc0=%h want 1 1c007000", fb_count, fb_pc0);
    end
    drain(ok);
  endtask

  task automatic test_flush();
    id_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bundle((i == 2) ? 2'b01 : 2'b11, 32'h1c00_8000 + 32'(i * 8), 32'h1c00_8004 + 32'(i * 8),
             1'b0, 7'd0, 2'b00, 32'd0);
      go(1);
    end
    bundle(2'b11, 32'h1c00_9000, 32'h1c00_9004, 1'b0, 7'd0, 2'b00, 32'd0);
    flush      = 1'b1;
    id_allowin = 1'b1;
    #1;
    checks++;
    if (fb_count !== 4'd5 || fb_readygo !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle got count=%0d rdy=%b want 5 1", fb_count, fb_readygo);
    end
    go(1);
    flush      = 1'b0;
    id_allowin = 1'b0;
    idle();
    checks++;
    if (fb_count !== 4'd0 || fb_readygo !== 1'b0 || fb_allowin !== 1'b1) begin
      errors++;
      $display("FAIL flush_after got count=%0d rdy=%b allowin=%b want 0 0 1", fb_count,
               fb_readygo, fb_allowin);
    end
    go(1);
    checks++;
    if (fb_count !== 4'd0 || fb_mask !== 2'b00) begin
      errors++;
      $display("FAIL flush_stale got count=%0d mask=%b want 0 00", fb_count, fb_mask);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    id_allowin = 1'b0;
    bundle(2'b11, 32'h1c00_a000, 32'h1c00_a004, 1'b0, 7'd0, 2'b00, 32'd0);
    go(1);
    idle();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (fb_readygo !== 1'b0 || fb_mask !== 2'b00 || fb_count !== 4'd0 || fb_allowin !== 1'b1 ||
        fb_inst0 !== NOP || fb_pc0 !== 32'd0) begin
      errors++;
      $display("FAIL async_rst got rdy=%b mask=%b cnt=%0d allow=%b inst0=%h pc0=%h want 0 00 0 1 %h 0",
               fb_readygo, fb_mask, fb_count, fb_allowin, fb_inst0, fb_pc0, NOP);
    end
    go(1);
    rstn = 1'b1;
    bundle(2'b01, 32'h1c00_b000, 32'd0, 1'b0, 7'd0, 2'b00, 32'd0);
    go(1);
    idle();
    checks++;
    if (fb_count !== 4'd1 || fb_pc0 !== 32'h1c00_b000) begin
      errors++;
      $display("FAIL async_resume got count=%0d pc0=%h want 1 1c00b000", fb_count, fb_pc0);
    end
    drain(ok);
  endtask

  initial begin
    rstn          = 1'b0;
    flush         = 1'b0;
    id_allowin    = 1'b0;
    if_pc0        = '0;
    if_pc1        = '0;
    if_inst0      = '0;
    if_inst1      = '0;
    if_excp_code  = '0;
    if_badv       = '0;
    if_pred_npc   = '0;
    idle();
    test_reset();
    test_pass_through();
    test_full();
    test_pred_taken();
    test_exception();
    test_wrap();
    test_flush();
    test_async_reset();
    go(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
